axi3_led_regs: RTL
==================

# axi3_led_regs

AXI3 slave register block on the PS7 M_AXI_GP0 port, clocked by FCLK0, directly downstream of the PS7 GP0 master. It decodes a 16-byte register window and drives the 8 board LEDs from one of two sources: a software-written pattern or the top byte of a free-running counter. It replaces the fixed counter-to-LED path with a software-controllable one.

## Interface
- Parameters:
  - ID_W, default 12: AXI ID width.
  - ID_VALUE, default 32'h1ED8_0001: constant returned by the ID register.
- Ports, clock and reset first:
  - i_clk0  in  1  FCLK0, sole clock.
  - i_rst  in  1  reset, synchronous and active-high.
  - i_AXI_AW{ID,ADDR,LEN,SIZE,BURST,VALID}  in  ID_W/32/4/3/2/1  write address channel; LOCK/CACHE/PROT/QOS are accepted and ignored.
  - o_AXI_AWREADY  out  1
  - i_AXI_W{ID,DATA,STRB,LAST,VALID}  in  ID_W/32/4/1/1  write data channel; WID is ignored.
  - o_AXI_WREADY  out  1
  - o_AXI_B{ID,RESP,VALID}  out  ID_W/2/1;  i_AXI_BREADY  in  1
  - i_AXI_AR{ID,ADDR,LEN,SIZE,BURST,VALID}  in  as AW
  - o_AXI_ARREADY  out  1
  - o_AXI_R{ID,DATA,RESP,LAST,VALID}  out  ID_W/32/2/1/1;  i_AXI_RREADY  in  1
  - o_led  out  8  LED drive.

## Operation
- Register map (ADDR[3:2], 32-bit):
  - 0x0 LED: RW, bits [7:0].
  - 0x4 CTRL: RW, bit 0 = MODE (0 = LED register, 1 = counter).
  - 0x8 CNT: RW; increments by 1 every cycle, and a write takes priority over the increment.
  - 0xC ID: RO; returns ID_VALUE, writes are ignored with OKAY.
- o_led = MODE ? CNT[31:24] : LED[7:0].
- Decode errors:
  - A burst with ADDR[11:4] != 0, or with SIZE != 3'b010, returns SLVERR for the whole burst.
  - Writes in such a burst are dropped; reads return 0.
  - ADDR[31:12] is ignored (decoded upstream).
- Bursts:
  - LEN+1 beats.
  - INCR advances the address by 4 per beat, with ADDR[3:2] wrapping modulo 4.
  - FIXED holds the address.
  - WRAP is treated as INCR.
- Writes apply WSTRB per byte lane.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On AW handshake, capture ID, ADDR, SIZE, BURST and error flag, then go to W_DATA.
  - W_DATA: WREADY=1. Each beat commits at the handshake edge. On the beat with WLAST go to W_RESP. WLAST is trusted and the beat count is not checked.
  - W_RESP: BVALID=1, BID=captured ID, BRESP=OKAY (00) or SLVERR (10). On BREADY go to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake, capture fields and load the beat counter with LEN, then go to R_DATA.
  - R_DATA: RVALID=1, RID=captured ID, RLAST=(beat counter==0).
  - On each R handshake, decrement the counter and advance the address. After the RLAST handshake, return to R_IDLE.
- Read and write FSMs are independent and may be active simultaneously.

## Timing
- Reset:
  - All READY/VALID outputs are 0 during reset.
  - LED, CTRL and CNT are 0; o_led is 0.
  - B*/R* ID, data and resp outputs are 0; RLAST is 0.
  - AWREADY and ARREADY rise the first cycle after i_rst falls.
- All outputs are registered.
- Write:
  - AW handshake at cycle N gives WREADY=1 from N+1.
  - A register written by a beat at cycle M shows the new value (and o_led) from M+1.
  - The WLAST handshake at M gives BVALID from M+1.
  - The B handshake at K gives AWREADY from K+1.
- Read:
  - AR handshake at N gives RVALID from N+1, with RDATA sampled from register state at the end of cycle N.
  - Each subsequent beat presents data sampled at the previous handshake edge.
  - With RREADY held high, the pipeline delivers one beat per cycle.
- RVALID/BVALID and their payloads hold stable until accepted.
- Same-cycle read sample and write commit to the same register: the read returns the pre-write value.
- CNT read sampled at cycle N returns the value current in cycle N; 32'hFFFF_FFFF wraps to 0.
- Reset asserted mid-burst aborts both FSMs to the reset state on the next edge, with no response issued.

## Structure
- Package pl_axi_pkg holds:
  - AXI resp codes (OKAY, SLVERR), burst encodings (FIXED, INCR, WRAP) and SIZE_4B.
  - Register offsets (REG_LED, REG_CTRL, REG_CNT, REG_ID).
  - Write and read FSM state enums.
- One sub-module, axi3_beat_addr: combinational next-address calculation from (addr[3:2], burst), shared by both FSMs.
- Flops use the existing ff macros in their synchronous-reset form.

## Test plan
- Reset release: o_led=0, AWREADY=ARREADY=1 one cycle after reset; read 0xC -> RDATA=ID_VALUE, RRESP=00, RLAST=1.
- Single write 0x0 data 0xA5, STRB=4'b0001, AWID=0x3A -> o_led=0xA5 the cycle after the W handshake; BID=0x3A, BRESP=00.
- Write CTRL=1, then CNT=0x00FF_FFFF -> o_led=0x01 exactly 2 cycles after the CNT commit (0x00FF_FFFF at commit+1, 0x0100_0000 at commit+2); CNT write beats the increment.
- INCR read, ADDR=0x8, LEN=3, RREADY toggling 1/0 -> 4 beats from addresses 0x8, 0xC, 0x0, 0x4; RLAST only on the 4th; data held while RREADY=0.
- Address 0x10 write, and SIZE=1 read -> BRESP=10 with no register change; RRESP=10 and RDATA=0 on every beat.
- Concurrent: AR to 0x0 and a write beat of 0x5A to 0x0 handshake the same cycle -> RDATA = old LED; a subsequent read returns 0x5A. Reset asserted during a 4-beat read -> RVALID=0 next cycle, ARREADY=1 after release.

Source files
------------

// File: rtl/pl_axi_pkg.sv
// Shared AXI3 encodings, register offsets and FSM states
// for the PL LED register block.
package pl_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  localparam logic [1:0] REG_LED  = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_ID   = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic addr_err(
    input logic [7:0] page,
    input logic [2:0] size
  );
    return (page != 8'h00) || (size != SIZE_4B);
  endfunction

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] reg_rd(
    input logic [1:0]  idx,
    input logic [7:0]  led,
    input logic        mode,
    input logic [31:0] cnt,
    input logic [31:0] id
  );
    logic [31:0] res;
    unique case (idx)
      REG_LED:  res = {24'h0, led};
      REG_CTRL: res = {31'h0, mode};
      REG_CNT:  res = cnt;
      REG_ID:   res = id;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axi3_beat_addr.sv
// Next register index within the 16-byte window for one burst beat;
// WRAP and reserved encodings step like INCR.
module axi3_beat_addr
  import pl_axi_pkg::*;
(
  input  logic [1:0] i_idx,
  input  logic [1:0] i_burst,
  output logic [1:0] o_idx
);

  always_comb begin
    o_idx = i_idx + 2'd1;
    unique case (i_burst)
      BURST_FIXED: o_idx = i_idx;
      BURST_INCR:  o_idx = i_idx + 2'd1;
      BURST_WRAP:  o_idx = i_idx + 2'd1;
      default:     o_idx = i_idx + 2'd1;
    endcase
  end

endmodule

// File: rtl/axi3_led_regs.sv
// AXI3 slave with LED, CTRL, free-running CNT and ID registers;
// drives the board LEDs from software or from the counter.
module axi3_led_regs
  import pl_axi_pkg::*;
#(
  parameter int          ID_W     = 12,
  parameter logic [31:0] ID_VALUE = 32'h1ED8_0001
) (
  input  logic            i_clk0,
  input  logic            i_rst,
  input  logic [ID_W-1:0] i_AXI_AWID,
  input  logic [31:0]     i_AXI_AWADDR,
  input  logic [3:0]      i_AXI_AWLEN,
  input  logic [2:0]      i_AXI_AWSIZE,
  input  logic [1:0]      i_AXI_AWBURST,
  input  logic            i_AXI_AWVALID,
  output logic            o_AXI_AWREADY,
  input  logic [ID_W-1:0] i_AXI_WID,
  input  logic [31:0]     i_AXI_WDATA,
  input  logic [3:0]      i_AXI_WSTRB,
  input  logic            i_AXI_WLAST,
  input  logic            i_AXI_WVALID,
  output logic            o_AXI_WREADY,
  output logic [ID_W-1:0] o_AXI_BID,
  output logic [1:0]      o_AXI_BRESP,
  output logic            o_AXI_BVALID,
  input  logic            i_AXI_BREADY,
  input  logic [ID_W-1:0] i_AXI_ARID,
  input  logic [31:0]     i_AXI_ARADDR,
  input  logic [3:0]      i_AXI_ARLEN,
  input  logic [2:0]      i_AXI_ARSIZE,
  input  logic [1:0]      i_AXI_ARBURST,
  input  logic            i_AXI_ARVALID,
  output logic            o_AXI_ARREADY,
  output logic [ID_W-1:0] o_AXI_RID,
  output logic [31:0]     o_AXI_RDATA,
  output logic [1:0]      o_AXI_RRESP,
  output logic            o_AXI_RLAST,
  output logic            o_AXI_RVALID,
  input  logic            i_AXI_RREADY,
  output logic [7:0]      o_led
);

  wr_state_t       r_wstate;
  wr_state_t       w_wnext;
  logic            r_awready;
  logic            r_wready;
  logic            r_bvalid;
  logic [ID_W-1:0] r_bid;
  logic [1:0]      r_bresp;
  logic [1:0]      r_widx;
  logic [1:0]      r_wburst;
  logic            r_werr;
  logic [1:0]      w_widx_nx;

  rd_state_t       r_rstate;
  rd_state_t       w_rnext;
  logic            r_arready;
  logic            r_rvalid;
  logic [ID_W-1:0] r_rid;
  logic [31:0]     r_rdata;
  logic [1:0]      r_rresp;
  logic            r_rlast;
  logic [1:0]      r_ridx;
  logic [1:0]      r_rburst;
  logic            r_rerr;
  logic [3:0]      r_rcnt;
  logic [1:0]      w_ridx_nx;

  logic [7:0]      r_led;
  logic            r_mode;
  logic [31:0]     r_cnt;
  logic [7:0]      r_led_out;
  logic [7:0]      w_led_nx;
  logic            w_mode_nx;
  logic [31:0]     w_cnt_nx;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_err;
  logic w_ar_err;
  logic w_unused;

  assign w_aw_hs  = i_AXI_AWVALID & r_awready;
  assign w_w_hs   = i_AXI_WVALID & r_wready;
  assign w_b_hs   = r_bvalid & i_AXI_BREADY;
  assign w_ar_hs  = i_AXI_ARVALID & r_arready;
  assign w_r_hs   = r_rvalid & i_AXI_RREADY;
  assign w_aw_err = addr_err(i_AXI_AWADDR[11:4], i_AXI_AWSIZE);
  assign w_ar_err = addr_err(i_AXI_ARADDR[11:4], i_AXI_ARSIZE);

  // Upper address bits are decoded upstream; WLAST alone ends a burst.
  assign w_unused = ^{i_AXI_AWADDR[31:12], i_AXI_AWADDR[1:0],
                      i_AXI_ARADDR[31:12], i_AXI_ARADDR[1:0],
                      i_AXI_AWLEN, i_AXI_WID};

  axi3_beat_addr u_wr_addr (
    .i_idx   (r_widx),
    .i_burst (r_wburst),
    .o_idx   (w_widx_nx)
  );

  axi3_beat_addr u_rd_addr (
    .i_idx   (r_ridx),
    .i_burst (r_rburst),
    .o_idx   (w_ridx_nx)
  );

  always_comb begin
    w_wnext = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
      W_DATA:  if (w_w_hs && i_AXI_WLAST) w_wnext = W_RESP;
      W_RESP:  if (w_b_hs) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk0) begin
    if (i_rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_widx    <= 2'd0;
      r_wburst  <= BURST_FIXED;
      r_werr    <= 1'b0;
    end else begin
      r_wstate  <= w_wnext;
      r_awready <= (w_wnext == W_IDLE);
      r_wready  <= (w_wnext == W_DATA);
      r_bvalid  <= (w_wnext == W_RESP);
      if (w_aw_hs) begin
        r_bid    <= i_AXI_AWID;
        r_bresp  <= w_aw_err ? RESP_SLVERR : RESP_OKAY;
        r_widx   <= i_AXI_AWADDR[3:2];
        r_wburst <= i_AXI_AWBURST;
        r_werr   <= w_aw_err;
      end else if (w_w_hs) begin
        r_widx   <= w_widx_nx;
      end
    end
  end

  always_comb begin
    w_rnext = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // Read data is sampled from the pre-edge register state at each handshake.
  always_ff @(posedge i_clk0) begin
    if (i_rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
      r_ridx    <= 2'd0;
      r_rburst  <= BURST_FIXED;
      r_rerr    <= 1'b0;
      r_rcnt    <= 4'd0;
    end else begin
      r_rstate  <= w_rnext;
      r_arready <= (w_rnext == R_IDLE);
      r_rvalid  <= (w_rnext == R_DATA);
      if (w_ar_hs) begin
        r_rid    <= i_AXI_ARID;
        r_rresp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
        r_ridx   <= i_AXI_ARADDR[3:2];
        r_rburst <= i_AXI_ARBURST;
        r_rerr   <= w_ar_err;
        r_rcnt   <= i_AXI_ARLEN;
        r_rlast  <= (i_AXI_ARLEN == 4'd0);
        r_rdata  <= w_ar_err ? '0 :
                    reg_rd(i_AXI_ARADDR[3:2], r_led,
                           r_mode, r_cnt, ID_VALUE);
      end else if (w_r_hs) begin
        if (r_rlast) begin
          r_rlast <= 1'b0;
        end else begin
          r_rcnt  <= r_rcnt - 4'd1;
          r_ridx  <= w_ridx_nx;
          r_rlast <= (r_rcnt == 4'd1);
          r_rdata <= r_rerr ? '0 :
                     reg_rd(w_ridx_nx, r_led,
                            r_mode, r_cnt, ID_VALUE);
        end
      end
    end
  end

  always_comb begin
    w_led_nx  = r_led;
    w_mode_nx = r_mode;
    w_cnt_nx  = r_cnt + 32'd1;
    if (w_w_hs && !r_werr) begin
      unique case (r_widx)
        REG_LED:  if (i_AXI_WSTRB[0]) w_led_nx = i_AXI_WDATA[7:0];
        REG_CTRL: if (i_AXI_WSTRB[0]) w_mode_nx = i_AXI_WDATA[0];
        REG_CNT:  w_cnt_nx = strb_merge(r_cnt, i_AXI_WDATA, i_AXI_WSTRB);
        default:  w_led_nx = r_led;
      endcase
    end
  end

  always_ff @(posedge i_clk0) begin
    if (i_rst) begin
      r_led     <= 8'h00;
      r_mode    <= 1'b0;
      r_cnt     <= 32'h0;
      r_led_out <= 8'h00;
    end else begin
      r_led     <= w_led_nx;
      r_mode    <= w_mode_nx;
      r_cnt     <= w_cnt_nx;
      r_led_out <= w_mode_nx ? w_cnt_nx[31:24] : w_led_nx;
    end
  end

  assign o_AXI_AWREADY = r_awready;
  assign o_AXI_WREADY  = r_wready;
  assign o_AXI_BID     = r_bid;
  assign o_AXI_BRESP   = r_bresp;
  assign o_AXI_BVALID  = r_bvalid;
  assign o_AXI_ARREADY = r_arready;
  assign o_AXI_RID     = r_rid;
  assign o_AXI_RDATA   = r_rdata;
  assign o_AXI_RRESP   = r_rresp;
  assign o_AXI_RLAST   = r_rlast;
  assign o_AXI_RVALID  = r_rvalid;
  assign o_led         = r_led_out;

endmodule
